// File: rtl/rv32im_muldiv_unit.sv
// Multi-cycle RV32 M-extension unit: shift-add multiply and restoring divide.
// Define RV32IM_MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier instead.
module rv32im_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            mul_en,
  input  logic            div_en,
  input  logic [1:0]      sn,
  input  logic [1:0]      m_sel,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] hi, lo, opnd;
  logic [CW-1:0]   count;
  logic            op_mul, neg_prod, neg_rem;
  logic [1:0]      sel;

  logic              neg1, neg2, accept, div_zero, div_ovf;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_word;

  always_comb begin
    neg1     = sn[1] & rs1[XLEN-1];
    neg2     = sn[0] & rs2[XLEN-1];
    mag1     = neg1 ? (~rs1 + 1'b1) : rs1;
    mag2     = neg2 ? (~rs2 + 1'b1) : rs2;
    accept   = start && (state == IDLE) && !busy && (mul_en ^ div_en);
    div_zero = (rs2 == '0);
    div_ovf  = (sn == 2'b11) && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    // hi holds the partial product / partial remainder, lo the multiplier / quotient bits
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_diff = {1'b0, hi, lo[XLEN-1]} - {2'b00, opnd};
    prod_fix = neg_prod ? (~{hi, lo} + 1'b1) : {hi, lo};
    quo_fix  = neg_prod ? (~lo + 1'b1) : lo;
    rem_fix  = neg_rem ? (~hi + 1'b1) : hi;
    if (sel[1])
      fix_word = sel[0] ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    else
      fix_word = sel[0] ? rem_fix : quo_fix;
  end

`ifdef RV32IM_MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b, fast_prod;

  // 64-bit wraparound of the sign/zero-extended operands equals the 33x33 signed product
  always_comb begin
    fast_a    = {{XLEN{sn[1] & rs1[XLEN-1]}}, rs1};
    fast_b    = {{XLEN{sn[0] & rs2[XLEN-1]}}, rs2};
    fast_prod = fast_a * fast_b;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      count    <= '0;
      op_mul   <= 1'b0;
      neg_prod <= 1'b0;
      neg_rem  <= 1'b0;
      sel      <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (done) begin
            busy <= 1'b0;
          end else if (accept) begin
            busy     <= 1'b1;
            sel      <= m_sel;
            op_mul   <= mul_en;
            count    <= '0;
            neg_prod <= neg1 ^ neg2;
            neg_rem  <= neg1;
            if (div_en && div_zero) begin
              hi       <= rs1;
              lo       <= '1;
              neg_prod <= 1'b0;
              neg_rem  <= 1'b0;
              state    <= FIX;
            end else if (div_en && div_ovf) begin
              hi       <= '0;
              lo       <= {1'b1, {(XLEN-1){1'b0}}};
              neg_prod <= 1'b0;
              neg_rem  <= 1'b0;
              state    <= FIX;
            end else if (mul_en) begin
`ifdef RV32IM_MULDIV_FAST_MUL_EN
              {hi, lo} <= fast_prod;
              neg_prod <= 1'b0;
              state    <= FIX;
`else
              hi    <= '0;
              lo    <= mag2;
              opnd  <= mag1;
              state <= CALC;
`endif
            end else begin
              hi    <= '0;
              lo    <= mag1;
              opnd  <= mag2;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op_mul) begin
            {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
          end else if (!div_diff[XLEN+1]) begin
            hi <= div_diff[XLEN-1:0];
            lo <= {lo[XLEN-2:0], 1'b1};
          end else begin
            hi <= {hi[XLEN-2:0], lo[XLEN-1]};
            lo <= {lo[XLEN-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == CW'(XLEN-1))
            state <= FIX;
        end
        FIX: begin
          result <= fix_word;
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rv32im_muldiv_unit.md
Name: rv32im_muldiv_unit

Overview:
- Multi-cycle M-extension execution unit for the RV32IM core; the responder for the M-extension controls the control path emits (Mul_en, Div_en, sn, M_sel).
- Accepts a one-cycle start with operands and the decoded controls, then computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Returns a 32-bit result with a one-cycle done pulse; busy lets the datapath stall the pipeline while the unit is working.

Parameters:
- XLEN, 32, operand and result width; the iteration count equals XLEN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- mul_en  in  1  multiply request (Mul_en).
- div_en  in  1  divide request (Div_en).
- sn  in  2  signedness: sn[1]=1 means rs1 is signed, sn[0]=1 means rs2 is signed.
- m_sel  in  2  output select: m_sel[1]=1 means multiply, m_sel[0]=1 means high product word (mul) or remainder (div).
- rs1  in  XLEN  multiplicand / dividend.
- rs2  in  XLEN  multiplier / divisor.
- busy  out  1  high from the cycle after acceptance through the done cycle.
- done  out  1  one-cycle pulse; result is valid.
- result  out  XLEN  result, held from done until the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0; done=0; result=0; all internal registers cleared.
- Reset asserted mid-operation aborts the operation immediately, and no done is produced.
- Acceptance: start=1 in IDLE with mul_en^div_en=1.
  - Latch rs1, rs2, sn, m_sel and the operation.
  - start with both enables low or both high is ignored: no state change, no done.
  - start outside IDLE is ignored.
- States and transitions:
  - IDLE: waits for acceptance.
    - Normal accept goes to CALC with count=0.
    - A divide special case goes directly to FIX.
  - CALC: one iteration per clock, count increments.
    - After XLEN iterations (count=XLEN-1 on the transition edge), go to FIX.
  - FIX: apply sign correction, select the output word and write result.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency, with the accepting edge as E0:
  - Normal ops: done is high in the cycle after edge E0+XLEN+2, i.e. 34 clocks for XLEN=32.
  - Special-case divide: done after edge E0+2.
  - Throughput: the next start is accepted at earliest the cycle after done.
- Operand preparation:
  - An operand is negative iff its sn bit is 1 and its MSB is 1.
  - Magnitudes are formed with two's-complement negation.
  - The -2^31 magnitude is 2^31, held unsigned in XLEN bits.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 2*XLEN accumulator.
  - In FIX, negate the 64-bit product if neg1^neg2.
  - m_sel[0]=0 gives product[31:0]; m_sel[0]=1 gives product[63:32].
- Divide:
  - Restoring division on magnitudes: one quotient bit per cycle, MSB first.
  - Quotient is negated if neg1^neg2.
  - Remainder is negated if neg1; the remainder always takes the sign of the dividend.
  - m_sel[0]=0 gives the quotient; m_sel[0]=1 gives the remainder.
- Divide special cases (resolved at acceptance, no iterations):
  - Divide by zero (rs2=0): quotient=0xFFFFFFFF; remainder=rs1. Applies to signed and unsigned.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, sn=11): quotient=0x80000000; remainder=0.
- Control inputs and operands may change freely after acceptance; only latched copies are used.

Optional Feature:
- Macro: RV32IM_MULDIV_FAST_MUL_EN.
- Defined:
  - Multiply ops use a single-cycle combinational 33x33 signed product, with operands sign- or zero-extended per sn.
  - Multiplies go IDLE→FIX→DONE, so done appears after edge E0+2.
  - Divides are unchanged.
- Undefined:
  - Iterative shift-add multiply as described above.
  - No combinational multiplier is inferred.

Test Plan:
- Reset mid-CALC: start DIV 100/7, drop rst_n at iteration 10 → busy=0, done never pulses, result=0. After release, a new start works normally.
- MUL/MULH: rs1=0xFFFFFFFF (-1), rs2=0x00000002, sn=11.
  - m_sel=10 → result=0xFFFFFFFE.
  - m_sel=11 → result=0xFFFFFFFF.
  - Each completes in 34 clocks.
- MULHU/MULHSU: rs1=0xFFFFFFFF, rs2=0xFFFFFFFF.
  - sn=00, m_sel=11 → 0xFFFFFFFE.
  - sn=10 → 0xFFFFFFFF (-1 × 0xFFFFFFFF gives a high word of 0xFFFFFFFF).
- DIV/REM signs: rs1=-7 (0xFFFFFFF9), rs2=2, sn=11.
  - m_sel=00 → 0xFFFFFFFD (-3).
  - m_sel=01 → 0xFFFFFFFF (-1).
  - DIVU with sn=00 → 0x7FFFFFFC.
- Special cases:
  - DIV 5/0 → quotient 0xFFFFFFFF and REM 5, with done after 2 clocks.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Handshake: start while busy, and start with mul_en=div_en=1 in IDLE → both ignored. Exactly one done per accepted start, and result is held after done.
